// File: rtl/neuron_mac_if.sv
// ---------------------------------------------------------------------------
// neuron_mac_if
//   Bundle of the signals between the neuron MAC, its upstream element
//   stream, its weight memory read port and its activation output.
//
//   Signals
//     xin      upstream -> mac   signed input element
//     xvalid   upstream -> mac   xin valid this cycle
//     ren      mac -> memory     weight read enable
//     radd     mac -> memory     weight read address
//     win      memory -> mac     weight, valid the cycle after ren
//     out      mac -> consumer   activation
//     outvalid mac -> consumer   one-cycle pulse, out valid
//
//   Handshake: every stream here is valid-only. A beat is transferred in
//   each cycle its valid (xvalid, ren, outvalid) is high; there is no ready
//   and the receiver must always accept. win carries no valid of its own:
//   it is defined exactly one cycle after the matching ren.
//
//   Modports
//     slave  : the neuron_mac side
//     master : the environment side (upstream, weight memory, consumer)
// ---------------------------------------------------------------------------
interface neuron_mac_if #(
    parameter int DATAWIDTH    = 16,
    parameter int ADDRESSWIDTH = 10
);
    logic [DATAWIDTH-1:0]    xin;
    logic                    xvalid;
    logic                    ren;
    logic [ADDRESSWIDTH-1:0] radd;
    logic [DATAWIDTH-1:0]    win;
    logic [DATAWIDTH-1:0]    out;
    logic                    outvalid;

    modport slave (
        input  xin,
        input  xvalid,
        input  win,
        output ren,
        output radd,
        output out,
        output outvalid
    );

    modport master (
        output xin,
        output xvalid,
        output win,
        input  ren,
        input  radd,
        input  out,
        input  outvalid
    );
endinterface

// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac
//   Multiply-accumulate sequencer for one fully-connected neuron. Consumes
//   NUMWEIGHT signed Q-format inputs per sample, reads the matching weight
//   from a 1-cycle-latency weight memory, accumulates x*w, then adds the
//   bias, applies ReLU and positive saturation and emits one activation.
//
//   Ports
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset
//     bus   neuron_mac_if.slave (xin/xvalid in, ren/radd out, win in,
//           out/outvalid out)
//
//   Pipeline (xvalid of an element in cycle T):
//     T+1  stage 1: x delayed to line up with win, first/last flags
//     T+2  stage 2: full-width signed product
//     T+3  stage 3: accumulator / registered activation + outvalid
//
//   radd is the element counter itself, so it also serves as the
//   observable sequencer state.
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int                NUMWEIGHT    = 3,
    parameter int                ADDRESSWIDTH = 10,
    parameter int                DATAWIDTH    = 16,
    parameter int                FRACBITS     = 12,
    parameter logic [DATAWIDTH-1:0] BIAS      = '0,
    parameter int                ACCWIDTH     = 2*DATAWIDTH+ADDRESSWIDTH
) (
    input  logic         clk,
    input  logic         rstn,
    neuron_mac_if.slave  bus
);

    localparam int PW = 2*DATAWIDTH;
    localparam logic [ADDRESSWIDTH-1:0] LAST_IDX = ADDRESSWIDTH'(NUMWEIGHT-1);

    // Bias moved into the product Q format (2*FRACBITS fractional bits).
    localparam logic signed [ACCWIDTH-1:0] BIAS_SH =
        {{(ACCWIDTH-DATAWIDTH){BIAS[DATAWIDTH-1]}}, BIAS} << FRACBITS;

    // Largest positive activation, widened for comparison.
    localparam logic signed [ACCWIDTH-1:0] MAX_POS =
        {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};

    // ---------------- element counter ----------------
    logic [ADDRESSWIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (bus.xvalid) begin
            if (cnt == LAST_IDX) cnt <= '0;
            else                 cnt <= cnt + 1'b1;
        end
    end

    assign bus.ren  = bus.xvalid;
    assign bus.radd = cnt;

    // ---------------- stage 1: align x with win ----------------
    logic                        v1, first1, last1;
    logic signed [DATAWIDTH-1:0] x_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            x_d    <= '0;
        end else begin
            v1     <= bus.xvalid;
            first1 <= (cnt == '0);
            last1  <= (cnt == LAST_IDX);
            if (bus.xvalid) x_d <= bus.xin;
        end
    end

    // ---------------- stage 2: product ----------------
    logic                 v2, first2, last2;
    logic signed [PW-1:0] prod;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2     <= 1'b0;
            first2 <= 1'b0;
            last2  <= 1'b0;
            prod   <= '0;
        end else begin
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            if (v1) prod <= x_d * $signed(bus.win);
        end
    end

    // ---------------- stage 3: accumulate and finalize ----------------
    logic signed [ACCWIDTH-1:0] acc;
    logic signed [ACCWIDTH-1:0] prod_ext;
    logic signed [ACCWIDTH-1:0] sum;
    logic signed [ACCWIDTH-1:0] biased;
    logic signed [ACCWIDTH-1:0] shifted;
    logic [DATAWIDTH-1:0]       act;
    logic [DATAWIDTH-1:0]       out_q;
    logic                       outvalid_q;

    always_comb begin
        prod_ext = {{(ACCWIDTH-PW){prod[PW-1]}}, prod};
        // A first-flagged product restarts the sum, discarding whatever the
        // previous sample left behind; no idle cycle is needed between samples.
        sum      = first2 ? prod_ext : acc + prod_ext;
        biased   = sum + BIAS_SH;
        // Arithmetic shift: truncation toward -inf.
        shifted  = biased >>> FRACBITS;
        if (shifted[ACCWIDTH-1])     act = '0;
        else if (shifted > MAX_POS)  act = {1'b0, {(DATAWIDTH-1){1'b1}}};
        else                         act = shifted[DATAWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc        <= '0;
            out_q      <= '0;
            outvalid_q <= 1'b0;
        end else begin
            if (v2) acc <= sum;
            outvalid_q <= v2 && last2;
            if (v2 && last2) out_q <= act;
        end
    end

    assign bus.out      = out_q;
    assign bus.outvalid = outvalid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac
//   Three neuron_mac instances (BIAS 0, -2.0, +0.25) share one input stream;
//   each has its own weight memory model (1-cycle read latency) over a shared
//   weight table. Expected activations and arrival cycles are pushed when the
//   last element is issued; a negedge monitor pops and compares each pulse.
// ---------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NW = 3;

    logic clk;
    logic rstn;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) if0 ();
    neuron_mac_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) if1 ();
    neuron_mac_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) if2 ();

    neuron_mac #(.NUMWEIGHT(NW), .ADDRESSWIDTH(AW), .DATAWIDTH(DW),
                 .FRACBITS(12), .BIAS(16'h0000)) dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    neuron_mac #(.NUMWEIGHT(NW), .ADDRESSWIDTH(AW), .DATAWIDTH(DW),
                 .FRACBITS(12), .BIAS(16'hE000)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
    neuron_mac #(.NUMWEIGHT(NW), .ADDRESSWIDTH(AW), .DATAWIDTH(DW),
                 .FRACBITS(12), .BIAS(16'h0400)) dut2 (.clk(clk), .rstn(rstn), .bus(if2.slave));

    // ---------------- weight memory models ----------------
    logic [DW-1:0] wmem [NW];

    always @(posedge clk) if (if0.ren) if0.win <= wmem[if0.radd[1:0]];
    always @(posedge clk) if (if1.ren) if1.win <= wmem[if1.radd[1:0]];
    always @(posedge clk) if (if2.ren) if2.win <= wmem[if2.radd[1:0]];

    logic          ov_all  [3];
    logic [DW-1:0] out_all [3];
    assign ov_all[0] = if0.outvalid;  assign out_all[0] = if0.out;
    assign ov_all[1] = if1.outvalid;  assign out_all[1] = if1.out;
    assign ov_all[2] = if2.outvalid;  assign out_all[2] = if2.out;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
    int            cyc_q0[$], cyc_q1[$], cyc_q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_one(input int k, input logic [DW-1:0] got);
        logic [DW-1:0] e;
        int            c;
        int            n;
        n = (k == 0) ? exp_q0.size() : (k == 1) ? exp_q1.size() : exp_q2.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_outvalid dut%0d: got out=0x%0h expected no pulse (cycle %0d)", k, got, cyc);
        end else begin
            case (k)
                0:       begin e = exp_q0.pop_front(); c = cyc_q0.pop_front(); end
                1:       begin e = exp_q1.pop_front(); c = cyc_q1.pop_front(); end
                default: begin e = exp_q2.pop_front(); c = cyc_q2.pop_front(); end
            endcase
            check($sformatf("out_dut%0d", k), 32'(got), 32'(e));
            check($sformatf("latency_dut%0d", k), 32'(cyc), 32'(c));
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 3; k++)
                if (ov_all[k] === 1'b1) monitor_one(k, out_all[k]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_x(input logic [DW-1:0] x, input logic v);
        if0.xin = x;  if1.xin = x;  if2.xin = x;
        if0.xvalid = v;  if1.xvalid = v;  if2.xvalid = v;
    endtask

    task automatic drive_elem(input int idx, input logic [DW-1:0] x);
        @(posedge clk); #1;
        set_x(x, 1'b1);
        #1;
        check("ren_active", 32'(if0.ren), 32'd1);
        check("radd_elem", 32'(if0.radd), 32'(idx));
    endtask

    task automatic idle(input int n, input int hold_radd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            set_x(DW'($urandom_range(0, 16'hFFFF)), 1'b0);
            #1;
            if (hold_radd >= 0) begin
                check("ren_gap", 32'(if0.ren), 32'd0);
                check("radd_hold", 32'(if0.radd), 32'(hold_radd));
            end
        end
    endtask

    // One sample; gap idle cycles after every element but the last.
    // e0/e1/e2 are the hand-computed activations for BIAS 0 / -2.0 / +0.25.
    task automatic send_sample(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                               input logic [DW-1:0] x2, input int gap,
                               input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                               input logic [DW-1:0] e2);
        drive_elem(0, x0);
        idle(gap, 1);
        drive_elem(1, x1);
        idle(gap, 2);
        drive_elem(2, x2);
        exp_q0.push_back(e0);  cyc_q0.push_back(cyc + 3);
        exp_q1.push_back(e1);  cyc_q1.push_back(cyc + 3);
        exp_q2.push_back(e2);  cyc_q2.push_back(cyc + 3);
    endtask

    task automatic load_weights(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2);
        wmem[0] = w0;  wmem[1] = w1;  wmem[2] = w2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out0"}, 32'(if0.out), 32'd0);
        check({tag, "_out1"}, 32'(if1.out), 32'd0);
        check({tag, "_out2"}, 32'(if2.out), 32'd0);
        check({tag, "_ov0"},  32'(if0.outvalid), 32'd0);
        check({tag, "_ov1"},  32'(if1.outvalid), 32'd0);
        check({tag, "_ov2"},  32'(if2.outvalid), 32'd0);
        check({tag, "_radd"}, 32'(if0.radd), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0;
        set_x('0, 1'b0);
        if0.win = '0;  if1.win = '0;  if2.win = '0;
        load_weights(16'h1000, 16'h0800, 16'hFC00);
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        check("reset_ren", 32'(if0.ren), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2, 0);

        // Basic: 1.0*1.0 + 1.0*0.5 + 1.0*-0.25 = 1.25
        send_sample(16'h1000, 16'h1000, 16'h1000, 0, 16'h1400, 16'h0000, 16'h1800);
        idle(8, 0);
        check("out_hold", 32'(if0.out), 32'h1400);

        // Back-to-back, then a chain of fractional / truncation cases
        send_sample(16'h1000, 16'h1000, 16'h1000, 0, 16'h1400, 16'h0000, 16'h1800);
        send_sample(16'h2000, 16'h0000, 16'h0000, 0, 16'h2000, 16'h0000, 16'h2400);
        send_sample(16'h0001, 16'h0001, 16'h0000, 0, 16'h0001, 16'h0000, 16'h0401);
        send_sample(16'h0000, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0000, 16'h03FF);
        send_sample(16'h0001, 16'h0000, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0400);
        send_sample(16'h4000, 16'h0000, 16'h0000, 0, 16'h4000, 16'h2000, 16'h4400);
        idle(6, 0);

        // Gaps of 2 idle cycles between elements
        send_sample(16'h1000, 16'h1000, 16'h1000, 2, 16'h1400, 16'h0000, 16'h1800);
        idle(6, 0);

        // Positive saturation
        load_weights(16'h7FFF, 16'h7FFF, 16'h7FFF);
        send_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        idle(6, 0);

        // Negative full scale -> ReLU
        load_weights(16'h8000, 16'h8000, 16'h8000);
        send_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h0000, 16'h0000, 16'h0000);
        idle(6, 0);

        // Reset mid-sample: leave a nonzero activation, abort after element 1
        load_weights(16'h1000, 16'h0800, 16'hFC00);
        send_sample(16'h2000, 16'h0000, 16'h0000, 0, 16'h2000, 16'h0000, 16'h2400);
        idle(6, 0);
        drive_elem(0, 16'h1000);
        drive_elem(1, 16'h1000);
        @(posedge clk); #1;
        set_x('0, 1'b0);
        rstn = 1'b0;
        #2;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("midreset_hold");
        @(negedge clk);
        rstn = 1'b1;
        idle(2, 0);
        send_sample(16'h1000, 16'h1000, 16'h1000, 0, 16'h1400, 16'h0000, 16'h1800);
        idle(8, 0);

        check("drain_q0", 32'(exp_q0.size()), 32'd0);
        check("drain_q1", 32'(exp_q1.size()), 32'd0);
        check("drain_q2", 32'(exp_q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
